// File: rtl/alif_param_serializer_if.sv
// Config link bundle between host controller and the neuron parameter serializer.
// master: host side driving fields/start/ack; slave: serializer.
interface alif_param_serializer_if;
  logic       enable;
  logic       start;
  logic [2:0] weight_a;
  logic [2:0] weight_b;
  logic [7:0] leak_rate;
  logic [7:0] threshold_min;
  logic [3:0] leak_cycles;
  logic       params_ready_in;
  logic       load_mode;
  logic       serial_data;
  logic       busy;
  logic       done;
  logic       timeout_err;

  modport master (
    output enable, start,
    output weight_a, weight_b,
    output leak_rate, threshold_min,
    output leak_cycles,
    output params_ready_in,
    input  load_mode, serial_data,
    input  busy, done, timeout_err
  );

  modport slave (
    input  enable, start,
    input  weight_a, weight_b,
    input  leak_rate, threshold_min,
    input  leak_cycles,
    input  params_ready_in,
    output load_mode, serial_data,
    output busy, done, timeout_err
  );
endinterface

// File: rtl/alif_param_serializer.sv
// Serializes a 26-bit neuron parameter frame MSB-first and waits for the loader ack.
// Ports: clk, reset (async, active-high), bus (slave: fields/start/ack in, link/status out).
module alif_param_serializer #(
  parameter int BIT_CYCLES  = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    reset,
  alif_param_serializer_if.slave bus
);

  localparam int BCW = $clog2(BIT_CYCLES + 1);
  localparam int ACW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BIT_CYCLES - 1);
  localparam logic [ACW-1:0] AC_LAST = ACW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_ACK
  } state_t;

  state_t         state_q, state_d;
  logic [25:0]    shadow_q, shadow_d;
  logic [4:0]     bit_idx_q, bit_idx_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [ACW-1:0] ack_cnt_q, ack_cnt_d;
  logic           done_q, done_d;
  logic           tout_q, tout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      bit_idx_q <= '0;
      bit_cnt_q <= '0;
      ack_cnt_q <= '0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
    end else if (bus.enable) begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bit_idx_q <= bit_idx_d;
      bit_cnt_q <= bit_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      done_q    <= done_d;
      tout_q    <= tout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_idx_d = bit_idx_q;
    bit_cnt_d = bit_cnt_q;
    ack_cnt_d = ack_cnt_q;
    done_d    = 1'b0;
    tout_d    = tout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shadow_d  = {bus.weight_a, bus.weight_b,
                       bus.leak_rate, bus.threshold_min,
                       bus.leak_cycles};
          tout_d    = 1'b0;
          bit_idx_d = 5'd25;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == BC_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 5'd0) begin
            ack_cnt_d = '0;
            state_d   = WAIT_ACK;
          end else begin
            bit_idx_d = bit_idx_q - 5'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      WAIT_ACK: begin
        // An ack on the last allowed cycle beats the timeout.
        if (bus.params_ready_in) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (ack_cnt_q == AC_LAST) begin
          tout_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.load_mode   = (state_q == SHIFT);
  assign bus.serial_data = (state_q == SHIFT) & shadow_q[bit_idx_q];
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_alif_param_serializer.sv
// Directed bench for alif_param_serializer.
// Two instances: BIT_CYCLES=1 and BIT_CYCLES=3, both ACK_TIMEOUT=16.
module tb_alif_param_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [25:0] frame = 26'b101_010_10100101_00111100_1001;

  alif_param_serializer_if bus1 ();
  alif_param_serializer_if bus3 ();

  alif_param_serializer #(
    .BIT_CYCLES (1),
    .ACK_TIMEOUT(16)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  alif_param_serializer #(
    .BIT_CYCLES (3),
    .ACK_TIMEOUT(16)
  ) dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic lm(input bit b3);
    return b3 ? bus3.load_mode : bus1.load_mode;
  endfunction

  function automatic logic sd(input bit b3);
    return b3 ? bus3.serial_data : bus1.serial_data;
  endfunction

  function automatic logic [127:0] expand(input int b);
    logic [127:0] e;
    e = '0;
    for (int k = 0; k < 26 * b; k++)
      e = {e[126:0], frame[25 - k / b]};
    return e;
  endfunction

  task automatic set_fields();
    bus1.weight_a = 3'b101; bus3.weight_a = 3'b101;
    bus1.weight_b = 3'b010; bus3.weight_b = 3'b010;
    bus1.leak_rate = 8'hA5; bus3.leak_rate = 8'hA5;
    bus1.threshold_min = 8'h3C; bus3.threshold_min = 8'h3C;
    bus1.leak_cycles = 4'h9; bus3.leak_cycles = 4'h9;
  endtask

  task automatic pulse_start(input bit b3);
    if (b3) bus3.start = 1'b1;
    else bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    bus3.start = 1'b0;
  endtask

  // Samples the stream while load_mode is high; optional freeze on bus1.
  task automatic capture(input bit b3, input bit frz,
                         output int n, output logic [127:0] s);
    logic v;
    bit ok;
    n = 0;
    s = '0;
    while (lm(b3) && n < 200) begin
      s = {s[126:0], sd(b3)};
      n++;
      if (frz && n == 6) begin
        v = bus1.serial_data;
        bus1.enable = 1'b0;
        bus1.start = 1'b1;
        ok = 1'b1;
        repeat (5) begin
          tick();
          if (bus1.load_mode !== 1'b1 || bus1.serial_data !== v) ok = 1'b0;
        end
        bus1.enable = 1'b1;
        bus1.start = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
          errors++;
          $display("FAIL freeze: outputs moved lm=%b sd=%b want lm=1 sd=%b",
                   bus1.load_mode, bus1.serial_data, v);
        end
      end
      if (frz && n == 10) bus1.start = 1'b1;
      if (frz && n == 12) bus1.start = 1'b0;
      tick();
    end
  endtask

  task automatic ack_finish(input bit b3);
    if (b3) bus3.params_ready_in = 1'b1;
    else bus1.params_ready_in = 1'b1;
    tick();
    bus1.params_ready_in = 1'b0;
    bus3.params_ready_in = 1'b0;
    checks++;
    if ((b3 ? bus3.done : bus1.done) !== 1'b1) begin
      errors++;
      $display("FAIL ack_done: got %b want 1", b3 ? bus3.done : bus1.done);
    end
    checks++;
    if ((b3 ? bus3.timeout_err : bus1.timeout_err) !== 1'b0) begin
      errors++;
      $display("FAIL ack_terr: got %b want 0",
               b3 ? bus3.timeout_err : bus1.timeout_err);
    end
    checks++;
    if ((b3 ? bus3.busy : bus1.busy) !== 1'b0) begin
      errors++;
      $display("FAIL ack_busy: got %b want 0", b3 ? bus3.busy : bus1.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (bus1.load_mode !== 1'b0) begin
      errors++; $display("FAIL rst_lm: got %b want 0", bus1.load_mode);
    end
    checks++;
    if (bus1.serial_data !== 1'b0) begin
      errors++; $display("FAIL rst_sd: got %b want 0", bus1.serial_data);
    end
    checks++;
    if (bus1.busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b want 0", bus1.busy);
    end
    checks++;
    if (bus1.done !== 1'b0) begin
      errors++; $display("FAIL rst_done: got %b want 0", bus1.done);
    end
    checks++;
    if (bus1.timeout_err !== 1'b0) begin
      errors++; $display("FAIL rst_terr: got %b want 0", bus1.timeout_err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_frame1();
    int n;
    logic [127:0] s;
    set_fields();
    pulse_start(1'b0);
    bus1.weight_a = 3'b000;
    bus1.leak_rate = 8'h00;
    capture(1'b0, 1'b0, n, s);
    checks++;
    if (n != 26) begin
      errors++; $display("FAIL f1_len: got %0d want 26", n);
    end
    checks++;
    if (s !== expand(1)) begin
      errors++; $display("FAIL f1_data: got %h want %h", s, expand(1));
    end
    checks++;
    if (bus1.busy !== 1'b1) begin
      errors++; $display("FAIL f1_wait_busy: got %b want 1", bus1.busy);
    end
    set_fields();
    ack_finish(1'b0);
  endtask

  task automatic test_bit3();
    int n;
    logic [127:0] s;
    pulse_start(1'b1);
    capture(1'b1, 1'b0, n, s);
    checks++;
    if (n != 78) begin
      errors++; $display("FAIL b3_len: got %0d want 78", n);
    end
    checks++;
    if (s !== expand(3)) begin
      errors++; $display("FAIL b3_data: got %h want %h", s, expand(3));
    end
    ack_finish(1'b1);
  endtask

  task automatic test_timeout();
    int n;
    int c;
    logic [127:0] s;
    pulse_start(1'b0);
    capture(1'b0, 1'b0, n, s);
    c = 0;
    while (bus1.done !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    checks++;
    if (c != 16) begin
      errors++; $display("FAIL to_delay: got %0d want 16", c);
    end
    checks++;
    if (bus1.timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_terr: got %b want 1", bus1.timeout_err);
    end
    checks++;
    if (bus1.busy !== 1'b0) begin
      errors++; $display("FAIL to_busy: got %b want 0", bus1.busy);
    end
    tick();
    checks++;
    if (bus1.timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %b want 1", bus1.timeout_err);
    end
    pulse_start(1'b0);
    checks++;
    if (bus1.timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_clear: got %b want 0", bus1.timeout_err);
    end
    capture(1'b0, 1'b0, n, s);
    ack_finish(1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    logic [127:0] s;
    pulse_start(1'b0);
    repeat (15) tick();
    checks++;
    if (bus1.serial_data !== frame[10]) begin
      errors++;
      $display("FAIL mid_bit10: got %b want %b", bus1.serial_data, frame[10]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus1.load_mode !== 1'b0 || bus1.serial_data !== 1'b0 ||
        bus1.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: got lm=%b sd=%b busy=%b want 0 0 0",
               bus1.load_mode, bus1.serial_data, bus1.busy);
    end
    tick();
    reset = 1'b0;
    tick();
    pulse_start(1'b0);
    capture(1'b0, 1'b0, n, s);
    checks++;
    if (n != 26 || s !== expand(1)) begin
      errors++;
      $display("FAIL mid_refr: got n=%0d %h want 26 %h", n, s, expand(1));
    end
    ack_finish(1'b0);
    tick();
  endtask

  task automatic test_enable();
    int n;
    logic [127:0] s;
    pulse_start(1'b0);
    capture(1'b0, 1'b1, n, s);
    checks++;
    if (n != 26 || s !== expand(1)) begin
      errors++;
      $display("FAIL en_frame: got n=%0d %h want 26 %h", n, s, expand(1));
    end
    ack_finish(1'b0);
    bus1.enable = 1'b0;
    tick();
    tick();
    checks++;
    if (bus1.done !== 1'b1) begin
      errors++; $display("FAIL en_done_hold: got %b want 1", bus1.done);
    end
    bus1.enable = 1'b1;
    tick();
    checks++;
    if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
      errors++;
      $display("FAIL en_no_second: got done=%b busy=%b want 0 0",
               bus1.done, bus1.busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [127:0] s;
    pulse_start(1'b0);
    capture(1'b0, 1'b0, n, s);
    repeat (15) tick();
    bus1.params_ready_in = 1'b1;
    tick();
    bus1.params_ready_in = 1'b0;
    checks++;
    if (bus1.done !== 1'b1 || bus1.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL edge_ack: got done=%b terr=%b want 1 0",
               bus1.done, bus1.timeout_err);
    end
    checks++;
    if (bus1.load_mode !== 1'b0) begin
      errors++; $display("FAIL gap_lm: got %b want 0", bus1.load_mode);
    end
    pulse_start(1'b0);
    checks++;
    if (bus1.load_mode !== 1'b1 || bus1.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: got lm=%b busy=%b want 1 1",
               bus1.load_mode, bus1.busy);
    end
    capture(1'b0, 1'b0, n, s);
    checks++;
    if (n != 26 || s !== expand(1)) begin
      errors++;
      $display("FAIL b2b_frame: got n=%0d %h want 26 %h", n, s, expand(1));
    end
    ack_finish(1'b0);
  endtask

  initial begin
    bus1.enable = 1'b1; bus3.enable = 1'b1;
    bus1.start = 1'b0; bus3.start = 1'b0;
    bus1.params_ready_in = 1'b0; bus3.params_ready_in = 1'b0;
    set_fields();
    test_reset();
    test_frame1();
    test_bit3();
    test_timeout();
    test_reset_mid();
    test_enable();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
